balayage_afficheurs: RTL and testbench

//  Time-multiplexed driver for the 3-digit 7-segment display of the dice-type readout.

---
 rtl/balayage_afficheurs_pkg.sv | 37 +++
 rtl/balayage_afficheurs_decodeur.sv | 26 ++
 rtl/balayage_afficheurs.sv | 141 ++++++++++++++
 tb/tb_balayage_afficheurs.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/balayage_afficheurs_pkg.sv
// Shared constants for the 3-digit display scanner: glyphs, digit indices, snapshot layout.
// The snapshot carries a blink bit only when BALAYAGE_BLINK_EN is defined.
package balayage_pkg;

  localparam int SEG_W = 7;
  localparam int DIG_N = 3;
  localparam int BCD_W = 4;

  // Glyphs are active-high, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;

  localparam logic [1:0] DIG_CENT = 2'd0;
  localparam logic [1:0] DIG_DIZ  = 2'd1;
  localparam logic [1:0] DIG_UNIT = 2'd2;

  typedef struct packed {
    logic [BCD_W-1:0] d0;
    logic [BCD_W-1:0] d1;
    logic [BCD_W-1:0] d2;
    logic             en0;
    logic             en1;
`ifdef BALAYAGE_BLINK_EN
    logic             blink;
`endif
  } snap_t;

endpackage

// File: rtl/balayage_afficheurs_decodeur.sv
// BCD code to active-high 7-segment glyph; codes 10-15 render as a dash.
module decodeur_7seg
  import balayage_pkg::*;
(
  input  logic [BCD_W-1:0] code,
  output logic [SEG_W-1:0] glyph
);

  always_comb begin
    glyph = SEG_DASH;
    case (code)
      4'd0: glyph = SEG_0;
      4'd1: glyph = SEG_1;
      4'd2: glyph = SEG_2;
      4'd3: glyph = SEG_3;
      4'd4: glyph = SEG_4;
      4'd5: glyph = SEG_5;
      4'd6: glyph = SEG_6;
      4'd7: glyph = SEG_7;
      4'd8: glyph = SEG_8;
      4'd9: glyph = SEG_9;
      default: glyph = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/balayage_afficheurs.sv
// Time-multiplexed 3-digit 7-segment scanner; inputs snapshotted once per frame.
// Define BALAYAGE_BLINK_EN to add the blink port and frame-counter display gating.
//
// idx      | meaning
// DIG_CENT | hundreds slot (frame starts here at presc==0)
// DIG_DIZ  | tens slot
// DIG_UNIT | units slot
module balayage_afficheurs
  import balayage_pkg::*;
#(
  parameter int DIV         = 1000,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
`ifdef BALAYAGE_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BCD_W-1:0] bcd0,
  input  logic [BCD_W-1:0] bcd1,
  input  logic [BCD_W-1:0] bcd2,
  input  logic             en0,
  input  logic             en1,
`ifdef BALAYAGE_BLINK_EN
  input  logic             blink,
`endif
  output logic [SEG_W-1:0] seg,
  output logic [DIG_N-1:0] an,
  output logic             frame
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic [PW-1:0]    presc;
  logic [1:0]       idx;
  logic [1:0]       idx_nxt;
  logic             tick;
  logic             frame_start;
  logic             blank;
  snap_t            snap;
  logic [BCD_W-1:0] code;
  logic [SEG_W-1:0] glyph;
  logic             vis;
  logic [DIG_N-1:0] sel;
  logic [SEG_W-1:0] seg_int;
  logic [DIG_N-1:0] an_int;

  assign tick        = (presc == PRESC_LAST);
  assign frame_start = (presc == '0) && (idx == DIG_CENT);

  always_ff @(posedge clk) begin
    if (rst)       presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) idx <= DIG_CENT;
    else     idx <= idx_nxt;
  end

  // Any illegal encoding falls back to the hundreds slot.
  always_comb begin
    idx_nxt = DIG_CENT;
    case (idx)
      DIG_CENT: idx_nxt = tick ? DIG_DIZ  : DIG_CENT;
      DIG_DIZ:  idx_nxt = tick ? DIG_UNIT : DIG_DIZ;
      DIG_UNIT: idx_nxt = tick ? DIG_CENT : DIG_UNIT;
      default:  idx_nxt = DIG_CENT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap <= '0;
    end else if (frame_start) begin
      snap.d0  <= bcd0;
      snap.d1  <= bcd1;
      snap.d2  <= bcd2;
      snap.en0 <= en0;
      snap.en1 <= en1;
`ifdef BALAYAGE_BLINK_EN
      snap.blink <= blink;
`endif
    end
  end

`ifdef BALAYAGE_BLINK_EN
  localparam int FW = $clog2(2 * BLINK_FRAMES);
  logic [FW-1:0] fcnt;

  // Advances on the last tick of a frame so fcnt equals the frame number mod 2*BLINK_FRAMES.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt <= '0;
    end else if (tick && idx == DIG_UNIT) begin
      if (fcnt == FW'(2 * BLINK_FRAMES - 1)) fcnt <= '0;
      else                                   fcnt <= fcnt + 1'b1;
    end
  end

  assign blank = snap.blink && (fcnt >= FW'(BLINK_FRAMES));
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    code = snap.d2;
    vis  = 1'b0;
    sel  = '0;
    case (idx)
      DIG_CENT: begin code = snap.d0; vis = snap.en1; sel = 3'b001; end
      DIG_DIZ:  begin code = snap.d1; vis = snap.en0; sel = 3'b010; end
      DIG_UNIT: begin code = snap.d2; vis = 1'b1;     sel = 3'b100; end
      default:  begin code = snap.d2; vis = 1'b0;     sel = '0;     end
    endcase
    seg_int = vis ? glyph : '0;
    // The first cycle of each slot stays dark to avoid ghosting from the previous digit.
    an_int  = (vis && presc != '0 && !blank) ? sel : '0;
  end

  decodeur_7seg u_dec (
    .code  (code),
    .glyph (glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seg   <= {SEG_W{SEG_ACT_LOW}};
      an    <= {DIG_N{AN_ACT_LOW}};
      frame <= 1'b0;
    end else begin
      seg   <= seg_int ^ {SEG_W{SEG_ACT_LOW}};
      an    <= an_int ^ {DIG_N{AN_ACT_LOW}};
      frame <= frame_start;
    end
  end

endmodule

// File: tb/tb_balayage_afficheurs.sv
// Self-checking bench for balayage_afficheurs (DIV=4, active-low outputs, BLINK_FRAMES=2).
// Blink scenarios run only when BALAYAGE_BLINK_EN is defined.
module tb_balayage_afficheurs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] bcd0 = '0, bcd1 = '0, bcd2 = '0;
  logic       en0 = 1'b0, en1 = 1'b0;
`ifdef BALAYAGE_BLINK_EN
  logic       blink = 1'b0;
`endif
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  balayage_afficheurs #(
    .DIV(4), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
`ifdef BALAYAGE_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk(clk), .rst(rst), .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2),
    .en0(en0), .en1(en1),
`ifdef BALAYAGE_BLINK_EN
    .blink(blink),
`endif
    .seg(seg), .an(an), .frame(frame)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] c);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (c < 4'd10) ? tbl[c] : 7'h40;
  endfunction

  // Model: t = cycles since reset release; slot = (t/4)%3, frame number = t/12.
  int         t = 0;
  bit         mvalid = 1'b0;
  logic [3:0] m_d [3];
  logic       m_en0, m_en1, m_blink;
  logic [6:0] exp_seg;
  logic [2:0] exp_an;
  logic       exp_frame;

  always @(posedge clk) begin
    int slot, p;
    logic [3:0] c;
    logic v, bl;
    if (rst) begin
      exp_seg = 7'h7F; exp_an = 3'b111; exp_frame = 1'b0;
      t = 0; m_d = '{4'd0, 4'd0, 4'd0}; m_en0 = 0; m_en1 = 0; m_blink = 0;
    end else begin
      slot = (t / 4) % 3;
      p    = t % 4;
      c    = m_d[slot];
      v    = (slot == 0) ? m_en1 : (slot == 1) ? m_en0 : 1'b1;
      bl   = m_blink && (((t / 12) % 4) >= 2);
      exp_seg   = v ? ~glyph(c) : 7'h7F;
      exp_an    = 3'b111;
      if (v && p != 0 && !bl) exp_an[slot] = 1'b0;
      exp_frame = (t % 12 == 0);
      if (t % 12 == 0) begin
        m_d = '{bcd0, bcd1, bcd2}; m_en0 = en0; m_en1 = en1;
`ifdef BALAYAGE_BLINK_EN
        m_blink = blink;
`endif
      end
      t++;
    end
    mvalid = 1'b1;
  end

  always @(posedge clk) begin
    #1;
    if (mvalid) begin
      chk("model_seg", {25'd0, seg}, {25'd0, exp_seg});
      chk("model_an", {29'd0, an}, {29'd0, exp_an});
      chk("model_frame", {31'd0, frame}, {31'd0, exp_frame});
    end
  end

  int         lowc [3];
  logic [6:0] segd [3];
  int         ghost, act_total;
  logic       frame0;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_seg", {25'd0, seg}, 32'h7F);
      chk("rst_an", {29'd0, an}, 32'h7);
      chk("rst_frame", {31'd0, frame}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Observe the 12 output cycles of one frame; optionally change bcd2 after sample chg_at.
  task automatic frame_obs(input int chg_at, input logic [3:0] chg_val);
    lowc = '{0, 0, 0}; segd = '{7'h00, 7'h00, 7'h00}; ghost = 0; act_total = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (k == 0) frame0 = frame;
      if (k % 4 == 0 && an == 3'b111) ghost++;
      if (an != 3'b111) act_total++;
      for (int d = 0; d < 3; d++)
        if (!an[d]) begin lowc[d]++; segd[d] = seg; end
      if (k == chg_at) bcd2 = chg_val;
    end
  endtask

  initial begin
    // Reset, then d20
    bcd0 = 4'd0; bcd1 = 4'd2; bcd2 = 4'd0; en0 = 1'b1; en1 = 1'b0;
    do_reset();
    frame_obs(-1, 4'd0);
    chk("frame_after_rst", {31'd0, frame0}, 32'd1);
    chk("d20_cent_low", lowc[0], 32'd0);
    chk("d20_diz_low", lowc[1], 32'd3);
    chk("d20_diz_seg", {25'd0, segd[1]}, 32'h24);
    chk("d20_unit_low", lowc[2], 32'd3);
    chk("d20_unit_seg", {25'd0, segd[2]}, 32'h40);
    chk("d20_ghost", ghost, 32'd3);

    // d100 with dash on tens
    bcd0 = 4'd1; bcd1 = 4'd10; bcd2 = 4'd0; en0 = 1'b1; en1 = 1'b1;
    do_reset();
    frame_obs(-1, 4'd0);
    chk("d100_cent_seg", {25'd0, segd[0]}, 32'h79);
    chk("d100_diz_seg", {25'd0, segd[1]}, 32'h3F);
    chk("d100_unit_seg", {25'd0, segd[2]}, 32'h40);
    chk("d100_cent_low", lowc[0], 32'd3);

    // Mid-frame change of units is deferred to the next frame
    bcd0 = 4'd1; bcd1 = 4'd2; bcd2 = 4'd6;
    do_reset();
    frame_obs(5, 4'd4);
    chk("tear_unit_old", {25'd0, segd[2]}, 32'h02);
    frame_obs(-1, 4'd0);
    chk("tear_unit_new", {25'd0, segd[2]}, 32'h19);
    chk("tear_frame", {31'd0, frame0}, 32'd1);

    // Reset during units slot, restart with new snapshot
    bcd0 = 4'd4; bcd1 = 4'd5; bcd2 = 4'd6;
    do_reset();
    repeat (9) @(posedge clk);
    #1;
    bcd0 = 4'd7; bcd1 = 4'd8; bcd2 = 4'd9;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_seg", {25'd0, seg}, 32'h7F);
    chk("midrst_an", {29'd0, an}, 32'h7);
    chk("midrst_frame", {31'd0, frame}, 32'd0);
    rst = 1'b0;
    frame_obs(-1, 4'd0);
    chk("midrst_restart", {31'd0, frame0}, 32'd1);
    chk("midrst_cent_seg", {25'd0, segd[0]}, 32'h78);
    chk("midrst_cent_low", lowc[0], 32'd3);

`ifdef BALAYAGE_BLINK_EN
    blink = 1'b1;
    do_reset();
    for (int f = 0; f < 4; f++) begin
      frame_obs(-1, 4'd0);
      chk("blink_on_active", act_total, (f < 2) ? 32'd9 : 32'd0);
    end
    blink = 1'b0;
    for (int f = 4; f < 8; f++) begin
      frame_obs(-1, 4'd0);
      chk("blink_off_active", act_total, 32'd9);
    end
`endif

    repeat (2) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
